any1_core_lite: RTL and testbench
=================================

Name: any1_core_lite

Overview:
- Simplified in-order ANY-1 processor core: fetches 128-bit instruction bundles (four 32-bit instructions) over a Wishbone-style 128-bit bus and executes ADDI, BNE, STO and NOP one at a time.
- Sits at the top of the CPU hierarchy as the single bus master for instruction fetch and data stores.
- Intended as a bring-up core and a bus-protocol reference for the full out-of-order machine.

Parameters:
- RSTPC, 32'hFFFC0000, program counter loaded at reset.
- NMIVEC, 32'hFFFC0100, NMI vector address.

Ports:
- clk_i  in  1  core clock; sole clock, all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- wc_clk_i  in  1  wall-clock tick; sampled in clk_i domain, rising edge increments internal 64-bit tick counter.
- nmi_i  in  1  non-maskable interrupt, rising-edge sensitive.
- irq_i  in  1  maskable interrupt request; ignored by this core.
- cause_i  in  8  interrupt cause code; latched on NMI entry.
- vpa_o  out  1  valid program address: high during instruction-fetch bus cycles.
- cyc_o  out  1  bus cycle active.
- stb_o  out  1  bus strobe.
- ack_i  in  1  bus acknowledge.
- we_o  out  1  write enable.
- sel_o  out  16  byte-lane selects.
- adr_o  out  32  byte address.
- dat_i  in  128  read data.
- dat_o  out  128  write data.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc=RSTPC; bundle buffer invalid; all 64 registers cleared; state IFETCH.
  - Outputs: cyc_o, stb_o, we_o, vpa_o = 0; sel_o, adr_o, dat_o = 0.
- Instruction encoding (bits), opcode in [7:0]:
  - ADDI=8'h04: Rt[13:8], Ra[19:14], imm[31:20] sign-extended to 64; Rt = Ra + imm.
  - BNE=8'h29: Ra[19:14], Rb[25:20], disp[31:26] signed, in instruction units; if Ra != Rb then pc = pc + disp*4, else pc += 4.
  - STO=8'h70: Rs[13:8], Ra[19:14], disp[31:20] signed bytes; mem64[Ra+disp] = Rs.
  - NOP=8'hF1; any other opcode executes as NOP. NOP_INSN = 32'h000000F1.
  - Register file: 64 x 64 bits; r0 reads as 0, and writes to r0 are discarded.
- State machine: IFETCH -> EXEC -> (STORE -> EXEC_DONE) -> IFETCH.
  - IFETCH, buffer valid and tag==pc[31:4]: go directly to EXEC, no bus cycle.
  - IFETCH, otherwise: assert cyc_o=stb_o=vpa_o=1, we_o=0, sel_o=16'hFFFF, adr_o={pc[31:4],4'h0}. Hold all until ack_i=1; on ack capture dat_i into the buffer, set tag and valid, deassert cyc/stb/vpa the same edge, go to EXEC.
  - EXEC (one cycle): instruction = buffer slot pc[3:2], where slot 0 = bits [31:0]. Performs the ADDI/BNE/NOP update, pc += 4 for non-branches. STO goes to STORE.
  - STORE: address a = Ra+disp (low 32 bits). Drive cyc_o=stb_o=we_o=1, vpa_o=0, adr_o={a[31:3],3'b000}, dat_o={Rs,Rs}, sel_o=16'hFF00 if a[3] else 16'h00FF. Hold until ack_i; then drop the bus, pc += 4, go to IFETCH.
  - Misaligned store addresses are force-aligned (low 3 bits ignored).
- Bus:
  - Only one cycle outstanding; no retry/error.
  - Minimum bus cycle is 2 clocks when ack arrives the cycle after cyc.
  - cyc_o is never asserted in the cycle following an ack, so there are no back-to-back requests.
- Branch taken invalidates nothing; re-fetch occurs only when the target lies in a different 16-byte bundle.
- Stores do not update the bundle buffer (no self-modifying code support).
- NMI:
  - Rising edge of nmi_i is latched as pending.
  - Taken at the next IFETCH entry, never mid-bus-cycle: epc=pc, cause=cause_i, pc=NMIVEC.
- pc wraps modulo 2^32.

Test Plan:
- Reset release: first bus cycle has adr_o=32'hFFFC0000, vpa_o=1, we_o=0, sel_o=16'hFFFF; all outputs are 0 while rst_i=0.
- Bundle {NOP,NOP,NOP,ADDI r4=r4+1} (ADDI in bits [127:96]): after 4 instructions r4=1; exactly one fetch cycle for the bundle.
- ADDI with imm=12'hFFF on r6=0 -> r6=64'hFFFF_FFFF_FFFF_FFFF; ADDI targeting r0 leaves r0=0.
- STO r3 -> [r0+0x10] with r3=5: bus write adr_o=0x10, we_o=1, sel_o=16'h00FF, dat_o[63:0]=5; pc advances only after ack_i.
- Loop of ADDI r4+=1 then BNE r4,r7,-1 with r7=3: loop exits with r4=3; branch back within the bundle causes no re-fetch.
- Delayed ack (ack_i low 5 cycles): cyc/stb/adr held stable until ack. nmi_i pulse with cause_i=8'h20: next fetch at 0xFFFC0100, epc=interrupted pc, cause=8'h20. Async reset asserted mid-store drops cyc_o immediately.

Source files
------------

// File: rtl/any1_core_lite_if.sv
// 128-bit Wishbone-style bus between the lite core and memory.
// The core is the master; memory/bridge is the slave.
interface any1_core_lite_if;
  logic         vpa_o;
  logic         cyc_o;
  logic         stb_o;
  logic         ack_i;
  logic         we_o;
  logic [15:0]  sel_o;
  logic [31:0]  adr_o;
  logic [127:0] dat_i;
  logic [127:0] dat_o;

  modport master (
    output vpa_o, cyc_o, stb_o, we_o,
    output sel_o, adr_o, dat_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  vpa_o, cyc_o, stb_o, we_o,
    input  sel_o, adr_o, dat_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/any1_core_lite.sv
// ANY-1 lite core: in-order ADDI/BNE/STO/NOP over a 128-bit bus.
// One bundle buffer, one bus cycle at a time, edge-latched NMI.
module any1_core_lite #(
  parameter logic [31:0] RSTPC  = 32'hFFFC0000,
  parameter logic [31:0] NMIVEC = 32'hFFFC0100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wc_clk_i,
  input  logic       nmi_i,
  input  logic       irq_i,
  input  logic [7:0] cause_i,
  any1_core_lite_if.master bus
);
  typedef enum logic [1:0] {
    IFETCH, EXEC, STORE, EXEC_DONE
  } state_t;

  state_t       r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_epc;
  logic [7:0]   r_cause;
  logic [127:0] r_buf;
  logic [27:0]  r_tag;
  logic         r_bv;
  logic [63:0]  r_rf [64];
  logic         r_nmi_d;
  logic         r_nmi_pend;
  logic         r_wc_d;
  logic [63:0]  r_tick;
  logic         r_vpa;
  logic         r_cyc;
  logic         r_stb;
  logic         r_we;
  logic [15:0]  r_sel;
  logic [31:0]  r_adr;
  logic [127:0] r_dat;

  logic [31:0]  w_insn;
  logic [7:0]   w_op;
  logic [5:0]   w_rt;
  logic [5:0]   w_ra;
  logic [5:0]   w_rb;
  logic [63:0]  w_ra_v;
  logic [63:0]  w_rb_v;
  logic [63:0]  w_rt_v;
  logic [63:0]  w_imm;
  logic [63:0]  w_sum;
  logic [31:0]  w_pc4;
  logic [31:0]  w_br;
  logic         w_hit;
  logic         w_addi;
  logic         w_bne;
  logic         w_sto;
  logic         w_nmi_edge;
  logic         w_unused;

  assign w_insn = r_buf[{r_pc[3:2], 5'd0} +: 32];
  assign w_op   = w_insn[7:0];
  assign w_rt   = w_insn[13:8];
  assign w_ra   = w_insn[19:14];
  assign w_rb   = w_insn[25:20];
  assign w_ra_v = r_rf[w_ra];
  assign w_rb_v = r_rf[w_rb];
  assign w_rt_v = r_rf[w_rt];
  // ADDI immediate and STO displacement share bits [31:20]
  assign w_imm  = {{52{w_insn[31]}}, w_insn[31:20]};
  assign w_sum  = w_ra_v + w_imm;
  assign w_pc4  = r_pc + 32'd4;
  assign w_br   = r_pc + {{24{w_insn[31]}}, w_insn[31:26], 2'b00};
  assign w_hit  = r_bv && (r_tag == r_pc[31:4]);
  assign w_addi = (w_op == 8'h04);
  assign w_bne  = (w_op == 8'h29);
  assign w_sto  = (w_op == 8'h70);
  assign w_nmi_edge = nmi_i & ~r_nmi_d;
  assign w_unused   = ^{irq_i, r_tick, r_epc, r_cause};

  assign bus.vpa_o = r_vpa;
  assign bus.cyc_o = r_cyc;
  assign bus.stb_o = r_stb;
  assign bus.we_o  = r_we;
  assign bus.sel_o = r_sel;
  assign bus.adr_o = r_adr;
  assign bus.dat_o = r_dat;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IFETCH;
      r_pc       <= RSTPC;
      r_epc      <= '0;
      r_cause    <= '0;
      r_buf      <= '0;
      r_tag      <= '0;
      r_bv       <= 1'b0;
      r_nmi_d    <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_wc_d     <= 1'b0;
      r_tick     <= '0;
      r_vpa      <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      for (int i = 0; i < 64; i++)
        r_rf[i] <= '0;
    end else begin
      r_nmi_d <= nmi_i;
      r_wc_d  <= wc_clk_i;
      if (wc_clk_i & ~r_wc_d)
        r_tick <= r_tick + 64'd1;
      if (w_nmi_edge)
        r_nmi_pend <= 1'b1;
      unique case (r_state)
        IFETCH: begin
          if (r_cyc) begin
            if (bus.ack_i) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_vpa   <= 1'b0;
              r_buf   <= bus.dat_i;
              r_tag   <= r_pc[31:4];
              r_bv    <= 1'b1;
              r_state <= EXEC;
            end
          end else if (r_nmi_pend) begin
            // a new edge in this same cycle stays pending
            r_epc      <= r_pc;
            r_cause    <= cause_i;
            r_pc       <= NMIVEC;
            r_nmi_pend <= w_nmi_edge;
          end else if (w_hit) begin
            r_state <= EXEC;
          end else begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_vpa <= 1'b1;
            r_we  <= 1'b0;
            r_sel <= 16'hFFFF;
            r_adr <= {r_pc[31:4], 4'h0};
          end
        end
        EXEC: begin
          unique case (1'b1)
            w_addi: begin
              if (w_rt != 6'd0)
                r_rf[w_rt] <= w_sum;
              r_pc    <= w_pc4;
              r_state <= IFETCH;
            end
            w_bne: begin
              r_pc    <= (w_ra_v != w_rb_v) ? w_br : w_pc4;
              r_state <= IFETCH;
            end
            w_sto: begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_vpa   <= 1'b0;
              r_adr   <= {w_sum[31:3], 3'b000};
              r_dat   <= {w_rt_v, w_rt_v};
              r_sel   <= w_sum[3] ? 16'hFF00 : 16'h00FF;
              r_state <= STORE;
            end
            default: begin
              r_pc    <= w_pc4;
              r_state <= IFETCH;
            end
          endcase
        end
        STORE: begin
          if (bus.ack_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_pc    <= w_pc4;
            r_state <= EXEC_DONE;
          end
        end
        EXEC_DONE: r_state <= IFETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_any1_core_lite.sv
// Bench for any1_core_lite: vector table, hand sequences and
// random programs checked against an ISA-level reference model.
module tb_any1_core_lite;
  localparam logic [31:0] RSTPC  = 32'hFFFC0000;
  localparam logic [31:0] NMIVEC = 32'hFFFC0100;
  localparam logic [31:0] NOP    = 32'h000000F1;

  typedef struct packed {
    logic        vpa;
    logic        we;
    logic [31:0] adr;
    logic [15:0] sel;
    logic [63:0] dat;
  } txn_t;

  typedef struct packed {
    logic [11:0] ia;
    logic [11:0] ib;
    logic [11:0] disp;
    logic [5:0]  rt;
    logic [63:0] edat;
    logic [31:0] eadr;
    logic [15:0] esel;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       wc_clk_i = 1'b0;
  logic       rst_i;
  logic       nmi_i;
  logic       irq_i;
  logic [7:0] cause_i;

  any1_core_lite_if bus();

  any1_core_lite dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wc_clk_i (wc_clk_i),
    .nmi_i    (nmi_i),
    .irq_i    (irq_i),
    .cause_i  (cause_i),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;
  always #37 wc_clk_i = ~wc_clk_i;

  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  txn_t log_q[$];
  txn_t exp_q[$];
  logic [127:0] mem [int unsigned];
  logic [31:0] prog[$];

  function automatic logic [31:0] f_addi(input logic [5:0] rt, input logic [5:0] ra, input logic [11:0] imm);
    return {imm, ra, rt, 8'h04};
  endfunction

  function automatic logic [31:0] f_bne(input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] d);
    return {d, rb, ra, 6'd0, 8'h29};
  endfunction

  function automatic logic [31:0] f_sto(input logic [5:0] rs, input logic [5:0] ra, input logic [11:0] d);
    return {d, ra, rs, 8'h70};
  endfunction

  function automatic logic [127:0] mem_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 4;
    if (mem.exists(k)) return mem[k];
    return {4{NOP}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic put_prog(input logic [31:0] base);
    for (int i = 0; i < prog.size(); i++) begin
      logic [31:0] a;
      logic [127:0] b;
      a = base + 32'(4 * i);
      b = mem_rd(a);
      b[a[3:2] * 32 +: 32] = prog[i];
      mem[a >> 4] = b;
    end
    prog.delete();
  endtask

  task automatic add_halt();
    prog.push_back(f_addi(6'd63, 6'd0, 12'd1));
    prog.push_back(f_bne(6'd63, 6'd0, 6'd0));
  endtask

  task automatic push_f(input logic [31:0] a);
    exp_q.push_back('{1'b1, 1'b0, a, 16'hFFFF, 64'd0});
  endtask

  task automatic push_s(input logic [31:0] a, input logic [15:0] s, input logic [63:0] d);
    exp_q.push_back('{1'b0, 1'b1, a, s, d});
  endtask

  // ISA-level model: emits the bus transactions a program must produce
  task automatic model_run(input logic [31:0] start);
    logic [63:0] rg [64];
    logic [31:0] pc;
    logic [31:0] w;
    logic [31:0] a;
    logic [127:0] b;
    logic [63:0] s;
    logic [27:0] tag;
    bit have;
    int d;
    exp_q.delete();
    foreach (rg[i]) rg[i] = '0;
    pc = start;
    tag = '0;
    have = 0;
    for (int n = 0; n < 800; n++) begin
      if (!have || tag != pc[31:4]) begin
        push_f(pc & 32'hFFFF_FFF0);
        have = 1;
        tag = pc[31:4];
      end
      b = mem_rd(pc);
      w = b[pc[3:2] * 32 +: 32];
      s = {{52{w[31]}}, w[31:20]};
      if (w[7:0] == 8'h04) begin
        if (w[13:8] != 0) rg[w[13:8]] = rg[w[19:14]] + s;
        pc = pc + 4;
      end else if (w[7:0] == 8'h29) begin
        if (rg[w[19:14]] != rg[w[25:20]]) begin
          d = $signed(w[31:26]);
          if (d == 0) break;
          pc = pc + 32'(d * 4);
        end else pc = pc + 4;
      end else if (w[7:0] == 8'h70) begin
        a = rg[w[19:14]][31:0] + s[31:0];
        push_s(a & ~32'h7, ((a / 8) % 2 == 1) ? 16'hFF00 : 16'h00FF, rg[w[13:8]]);
        pc = pc + 4;
      end else pc = pc + 4;
    end
  endtask

  task automatic cmp_logs(input string nm);
    chk({nm, " count"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s[%0d]: got vpa=%b we=%b adr=%h sel=%h dat=%h want vpa=%b we=%b adr=%h sel=%h dat=%h",
          nm, i, log_q[i].vpa, log_q[i].we, log_q[i].adr, log_q[i].sel, log_q[i].dat,
          exp_q[i].vpa, exp_q[i].we, exp_q[i].adr, exp_q[i].sel, exp_q[i].dat);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int idle;
    int last;
    idle = 0;
    last = -1;
    for (int c = 0; c < budget && idle < 40; c++) begin
      @(posedge clk_i);
      if (log_q.size() != last) begin
        last = log_q.size();
        idle = 0;
      end else idle++;
    end
  endtask

  task automatic run();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    log_q.delete();
    rst_i = 1'b1;
    wait_idle(3000);
  endtask

  task automatic load_base();
    mem.delete();
    prog.push_back(NOP);
    prog.push_back(NOP);
    prog.push_back(NOP);
    prog.push_back(f_addi(6'd4, 6'd4, 12'd1));
    prog.push_back(f_addi(6'd3, 6'd0, 12'd5));
    prog.push_back(f_sto(6'd3, 6'd0, 12'h010));
    prog.push_back(f_sto(6'd4, 6'd0, 12'h018));
    add_halt();
    put_prog(RSTPC);
    exp_q.delete();
    push_f(RSTPC);
    push_f(RSTPC + 32'h10);
    push_s(32'h10, 16'h00FF, 64'd5);
    push_s(32'h18, 16'hFF00, 64'd1);
    push_f(RSTPC + 32'h20);
  endtask

  initial begin : resp
    int wcnt;
    int need;
    logic busy;
    logic [50:0] hold;
    txn_t t;
    bus.ack_i = 1'b0;
    bus.dat_i = '0;
    busy = 1'b0;
    wcnt = 0;
    need = 0;
    hold = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        bus.ack_i = 1'b0;
        busy = 1'b0;
      end else if (bus.ack_i) begin
        bus.ack_i = 1'b0;
        busy = 1'b0;
        chk("cyc after ack", 128'(bus.cyc_o), 128'd0);
      end else if (bus.cyc_o) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          need = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          hold = {bus.stb_o, bus.vpa_o, bus.we_o, bus.sel_o, bus.adr_o};
          chk("stb with cyc", 128'(bus.stb_o), 128'd1);
        end else begin
          chk("bus hold", 128'({bus.stb_o, bus.vpa_o, bus.we_o, bus.sel_o, bus.adr_o}), 128'(hold));
        end
        if (wcnt >= need) begin
          bus.ack_i = 1'b1;
          bus.dat_i = mem_rd(bus.adr_o);
          t = '{bus.vpa_o, bus.we_o, bus.adr_o, bus.sel_o,
                bus.we_o ? bus.dat_o[63:0] : 64'd0};
          log_q.push_back(t);
          if (bus.we_o)
            chk("dat dup", 128'(bus.dat_o[127:64]), 128'(bus.dat_o[63:0]));
        end else wcnt++;
      end
    end
  end

  initial begin : main
    vec_t vt [7];
    bit seen;
    vt[0] = '{12'h000, 12'hFFF, 12'h040, 6'd6,  64'hFFFF_FFFF_FFFF_FFFF, 32'h40, 16'h00FF};
    vt[1] = '{12'h001, 12'h001, 12'h048, 6'd2,  64'd2,                   32'h48, 16'hFF00};
    vt[2] = '{12'h800, 12'h800, 12'h04D, 6'd5,  64'hFFFF_FFFF_FFFF_F000, 32'h48, 16'hFF00};
    vt[3] = '{12'h7FF, 12'h001, 12'h7F3, 6'd9,  64'h800,                 32'h7F0, 16'h00FF};
    vt[4] = '{12'h123, 12'hFFF, 12'h800, 6'd3,  64'h122,                 32'hFFFFF800, 16'h00FF};
    vt[5] = '{12'h055, 12'h010, 12'h010, 6'd0,  64'd0,                   32'h10, 16'h00FF};
    vt[6] = '{12'hFFF, 12'h001, 12'h008, 6'd10, 64'd0,                   32'h08, 16'hFF00};

    rst_i = 1'b0;
    nmi_i = 1'b0;
    irq_i = 1'b0;
    cause_i = 8'h00;
    ack_delay = 0;

    // reset state, then the basic bundle program
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset ctrl", 128'({bus.cyc_o, bus.stb_o, bus.we_o, bus.vpa_o, bus.sel_o, bus.adr_o}), 128'd0);
    chk("reset dat", bus.dat_o, 128'd0);
    load_base();
    log_q.delete();
    rst_i = 1'b1;
    wait_idle(3000);
    cmp_logs("base");

    foreach (vt[i]) begin
      mem.delete();
      prog.push_back(f_addi(6'd1, 6'd0, vt[i].ia));
      prog.push_back(f_addi(vt[i].rt, 6'd1, vt[i].ib));
      prog.push_back(f_sto(vt[i].rt, 6'd0, vt[i].disp));
      add_halt();
      put_prog(RSTPC);
      run();
      chk($sformatf("vec%0d count", i), 128'(log_q.size()), 128'd3);
      if (log_q.size() > 1) begin
        chk($sformatf("vec%0d we", i), 128'(log_q[1].we), 128'd1);
        chk($sformatf("vec%0d adr", i), 128'(log_q[1].adr), 128'(vt[i].eadr));
        chk($sformatf("vec%0d sel", i), 128'(log_q[1].sel), 128'(vt[i].esel));
        chk($sformatf("vec%0d dat", i), 128'(log_q[1].dat), 128'(vt[i].edat));
      end
    end

    // counted loop branching back inside one bundle
    mem.delete();
    prog.push_back(f_addi(6'd7, 6'd0, 12'd3));
    prog.push_back(f_addi(6'd4, 6'd4, 12'd1));
    prog.push_back(f_bne(6'd4, 6'd7, 6'h3F));
    prog.push_back(f_sto(6'd4, 6'd0, 12'h020));
    add_halt();
    put_prog(RSTPC);
    run();
    exp_q.delete();
    push_f(RSTPC);
    push_s(32'h20, 16'h00FF, 64'd3);
    push_f(RSTPC + 32'h10);
    cmp_logs("loop");
    model_run(RSTPC);
    cmp_logs("loop model");

    ack_delay = 5;
    load_base();
    run();
    cmp_logs("slow ack");
    ack_delay = 0;

    // NMI while spinning at RSTPC+4
    mem.delete();
    add_halt();
    put_prog(RSTPC);
    prog.push_back(f_bne(6'd63, 6'd0, 6'd0));
    put_prog(NMIVEC);
    run();
    cause_i = 8'h20;
    @(negedge clk_i);
    nmi_i = 1'b1;
    repeat (2) @(negedge clk_i);
    nmi_i = 1'b0;
    repeat (10) @(negedge clk_i);
    cause_i = 8'h55;
    wait_idle(500);
    exp_q.delete();
    push_f(RSTPC);
    push_f(NMIVEC);
    cmp_logs("nmi");
    chk("nmi epc", 128'(dut.r_epc), 128'(RSTPC + 32'h4));
    chk("nmi cause", 128'(dut.r_cause), 128'h20);

    // async reset in the middle of a stalled store
    mem.delete();
    prog.push_back(f_sto(6'd0, 6'd0, 12'h030));
    add_halt();
    put_prog(RSTPC);
    ack_delay = 50;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    log_q.delete();
    rst_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk_i);
      seen = bus.cyc_o && bus.we_o;
    end
    chk("store seen", 128'(seen), 128'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid-store rst cyc", 128'(bus.cyc_o), 128'd0);
    chk("mid-store rst ctrl", 128'({bus.stb_o, bus.we_o, bus.vpa_o, bus.sel_o, bus.adr_o}), 128'd0);
    ack_delay = 0;

    for (int p = 0; p < 10; p++) begin
      int n;
      logic [31:0] r;
      mem.delete();
      n = $urandom_range(8, 20);
      for (int i = 0; i < n; i++) begin
        r = $urandom;
        case ($urandom_range(0, 5))
          0, 1: prog.push_back(f_addi(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), r[11:0]));
          2: prog.push_back(f_sto(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), r[11:0]));
          3: prog.push_back(f_bne(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(1, 3))));
          4: prog.push_back(NOP);
          default: begin
            case (r[1:0])
              2'd0: r[7:0] = 8'h00;
              2'd1: r[7:0] = 8'h05;
              2'd2: r[7:0] = 8'h71;
              default: r[7:0] = 8'hF1;
            endcase
            prog.push_back(r);
          end
        endcase
      end
      repeat (4) prog.push_back(NOP);
      add_halt();
      put_prog(RSTPC);
      model_run(RSTPC);
      ack_delay = -1;
      run();
      cmp_logs($sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
